// File: rtl/pll_reset_pkg.sv
// Shared types and counter-width helpers for the PLL reset sequencer.
// Pure definitions; no timing or flow control.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        PLLRST    = 3'd4
    } seq_state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int DEF_STABLE_W  = $clog2(1024);
    localparam int DEF_GAP_W     = $clog2(16);
    localparam int DEF_TIMEOUT_W = $clog2(65536);

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Lock input, count clear and the staged reset outputs of the PLL reset sequencer.
// master = sequencer side, slave = PLL / consumer side.
interface pll_reset_sequencer_if #(
    parameter int CNT_W = 8
) ();
    logic             locked;
    logic             count_clr;
    logic             rst_mem;
    logic             rst_func;
    logic             rst_cpu;
    logic             ready;
    logic             pll_rst;
    logic [CNT_W-1:0] lock_loss_count;

    modport master (
        input  locked, count_clr,
        output rst_mem, rst_func, rst_cpu, ready, pll_rst, lock_loss_count
    );

    modport slave (
        output locked, count_clr,
        input  rst_mem, rst_func, rst_cpu, ready, pll_rst, lock_loss_count
    );
endinterface

// File: rtl/pll_reset_sequencer_sync.sv
// SYNC_STAGES-deep flop chain bringing the raw PLL lock into the clock domain.
// Latency SYNC_STAGES edges; async clear forces the output low.
module lock_synchroniser #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged reset release mem -> func -> cpu after a stable PLL lock; any lock loss after release began re-asserts all.
// No backpressure. Define PLL_RESET_SEQ_WATCHDOG_EN to add the WAIT_LOCK timeout that pulses pll_rst.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGE_GAP      = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int PLLRST_CYCLES  = 8,
    parameter int CNT_W          = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    pll_reset_sequencer_if.master bus
);
    localparam int SEQ_W = max3(cnt_w(STABLE_CYCLES), cnt_w(STAGE_GAP), cnt_w(PLLRST_CYCLES));

    // STABLE leaves on the edge where the count would reach STABLE_CYCLES-1.
    localparam logic [SEQ_W-1:0] STABLE_LAST = SEQ_W'(STABLE_CYCLES - 2);
    localparam logic [SEQ_W-1:0] GAP_LAST    = SEQ_W'(STAGE_GAP - 1);

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 2 || STAGE_GAP < 1 ||
        TIMEOUT_CYCLES < 2 || PLLRST_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
        $error("pll_reset_sequencer: parameter out of range");
    end

    logic             lock_s;
    seq_state_t       state_q;
    logic [SEQ_W-1:0] seq_cnt_q;
    logic             rst_mem_q;
    logic             rst_func_q;
    logic             rst_cpu_q;
    logic             ready_q;
    logic             loss_inc;
    logic [CNT_W-1:0] loss_cnt_q;
    logic [CNT_W-1:0] loss_cnt_d;

    lock_synchroniser #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (bus.locked),
        .q_o   (lock_s)
    );

    assign loss_inc = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s;

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    localparam int WDT_W = cnt_w(TIMEOUT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LAST  = WDT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SEQ_W-1:0] PRST_LAST = SEQ_W'(PLLRST_CYCLES - 1);

    logic [WDT_W-1:0] wdt_q;
    logic [WDT_W-1:0] wdt_d;
    logic             pll_rst_q;

    // Runs only while waiting without lock; anything else, including the timeout itself, clears it.
    always_comb begin
        wdt_d = '0;
        if ((state_q == WAIT_LOCK) && !lock_s && (wdt_q != WDT_LAST)) begin
            wdt_d = wdt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end

    assign bus.pll_rst = pll_rst_q;
`else
    assign bus.pll_rst = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= WAIT_LOCK;
            seq_cnt_q  <= '0;
            rst_mem_q  <= 1'b1;
            rst_func_q <= 1'b1;
            rst_cpu_q  <= 1'b1;
            ready_q    <= 1'b0;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
            pll_rst_q  <= 1'b0;
`endif
        end else if (loss_inc) begin
            state_q    <= WAIT_LOCK;
            seq_cnt_q  <= '0;
            rst_mem_q  <= 1'b1;
            rst_func_q <= 1'b1;
            rst_cpu_q  <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    seq_cnt_q <= '0;
                    if (lock_s) begin
                        state_q <= STABLE;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
                    end else if (wdt_q == WDT_LAST) begin
                        state_q   <= PLLRST;
                        pll_rst_q <= 1'b1;
`endif
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_q   <= WAIT_LOCK;
                        seq_cnt_q <= '0;
                    end else if (seq_cnt_q == STABLE_LAST) begin
                        state_q   <= RELEASE;
                        seq_cnt_q <= '0;
                        rst_mem_q <= 1'b0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    // rst_func_q doubles as the "which stage is next" flag.
                    if (seq_cnt_q == GAP_LAST) begin
                        seq_cnt_q <= '0;
                        if (rst_func_q) begin
                            rst_func_q <= 1'b0;
                        end else begin
                            rst_cpu_q <= 1'b0;
                            ready_q   <= 1'b1;
                            state_q   <= RUN;
                        end
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    seq_cnt_q <= '0;
                end
                PLLRST: begin
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
                    if (seq_cnt_q == PRST_LAST) begin
                        state_q   <= WAIT_LOCK;
                        seq_cnt_q <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 1'b1;
                    end
`else
                    state_q   <= WAIT_LOCK;
                    seq_cnt_q <= '0;
`endif
                end
                default: begin
                    state_q   <= WAIT_LOCK;
                    seq_cnt_q <= '0;
                end
            endcase
        end
    end

    // A clear coinciding with a loss keeps that loss.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (bus.count_clr) begin
            loss_cnt_d = loss_inc ? CNT_W'(1) : '0;
        end else if (loss_inc && (loss_cnt_q != {CNT_W{1'b1}})) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign bus.rst_mem         = rst_mem_q;
    assign bus.rst_func        = rst_func_q;
    assign bus.rst_cpu         = rst_cpu_q;
    assign bus.ready           = ready_q;
    assign bus.lock_loss_count = loss_cnt_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: vector table for loss/clear behaviour plus timed release sequences.
module tb_pll_reset_sequencer;
    logic clock;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;
    int order_err = 0;
    logic pll_rst_seen = 1'b0;

    pll_reset_sequencer_if #(.CNT_W(2)) bus ();

    pll_reset_sequencer #(
        .SYNC_STAGES    (2),
        .STABLE_CYCLES  (16),
        .STAGE_GAP      (4),
        .TIMEOUT_CYCLES (64),
        .PLLRST_CYCLES  (8),
        .CNT_W          (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            if ((!bus.rst_func && bus.rst_mem) || (!bus.rst_cpu && bus.rst_func) ||
                (bus.ready && bus.rst_cpu)) order_err++;
        end
        if (bus.pll_rst) pll_rst_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    function automatic int outs();
        return int'({bus.rst_mem, bus.rst_func, bus.rst_cpu, bus.ready});
    endfunction

    typedef struct {
        string      name;
        logic       locked;
        int         clr_at;   // edge within the row on which count_clr is high, 0 = never
        int         cycles;
        logic [3:0] exp_outs; // {rst_mem, rst_func, rst_cpu, ready}
        logic [1:0] exp_cnt;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int mem_fall, func_fall, cpu_fall, rdy_rise;

        vecs[0]  = '{"loss1_run",      1'b0, 0, 3,  4'b1110, 2'd1};
        vecs[1]  = '{"relock1",        1'b1, 0, 26, 4'b0001, 2'd1};
        vecs[2]  = '{"loss2_run",      1'b0, 0, 3,  4'b1110, 2'd2};
        vecs[3]  = '{"relock2",        1'b1, 0, 26, 4'b0001, 2'd2};
        vecs[4]  = '{"loss3_run",      1'b0, 0, 3,  4'b1110, 2'd3};
        vecs[5]  = '{"relock3",        1'b1, 0, 26, 4'b0001, 2'd3};
        vecs[6]  = '{"loss4_sat",      1'b0, 0, 3,  4'b1110, 2'd3};
        vecs[7]  = '{"relock4",        1'b1, 0, 26, 4'b0001, 2'd3};
        vecs[8]  = '{"clr_with_loss",  1'b0, 3, 3,  4'b1110, 2'd1};
        vecs[9]  = '{"clr_alone",      1'b0, 1, 2,  4'b1110, 2'd0};
        vecs[10] = '{"mid_release",    1'b1, 0, 20, 4'b0110, 2'd0};
        vecs[11] = '{"loss_release",   1'b0, 0, 3,  4'b1110, 2'd1};
        vecs[12] = '{"relock5",        1'b1, 0, 26, 4'b0001, 2'd1};

        bus.locked = 1'b0;
        bus.count_clr = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("reset_outs", outs(), 4'b1110);
        check("reset_count", int'(bus.lock_loss_count), 0);
        check("reset_pll_rst", int'(bus.pll_rst), 0);

        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // Clean lock
        mem_fall = 0; func_fall = 0; cpu_fall = 0; rdy_rise = 0;
        bus.locked = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (mem_fall == 0 && !bus.rst_mem) mem_fall = k;
            if (func_fall == 0 && !bus.rst_func) func_fall = k;
            if (cpu_fall == 0 && !bus.rst_cpu) cpu_fall = k;
            if (rdy_rise == 0 && bus.ready) rdy_rise = k;
        end
        check_range("clean_mem_fall", mem_fall, 17, 19);
        check("clean_func_gap", func_fall - mem_fall, 4);
        check("clean_cpu_gap", cpu_fall - func_fall, 4);
        check("clean_ready_edge", rdy_rise, cpu_fall);
        check("clean_count", int'(bus.lock_loss_count), 0);

        // Unstable lock: one-cycle dropout forces a full recount
        bus.locked = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        mem_fall = 0;
        for (int k = 1; k <= 40; k++) begin
            bus.locked = (k != 11);
            tick();
            if (mem_fall == 0 && !bus.rst_mem) mem_fall = k;
        end
        check_range("unstable_mem_fall", mem_fall, 29, 30);
        check("unstable_ready", int'(bus.ready), 1);
        check("unstable_count", int'(bus.lock_loss_count), 0);

        for (int i = 0; i < 13; i++) begin
            bus.locked = vecs[i].locked;
            for (int c = 1; c <= vecs[i].cycles; c++) begin
                bus.count_clr = (c == vecs[i].clr_at);
                tick();
            end
            bus.count_clr = 1'b0;
            check({vecs[i].name, "_outs"}, outs(), int'(vecs[i].exp_outs));
            check({vecs[i].name, "_count"}, int'(bus.lock_loss_count), int'(vecs[i].exp_cnt));
        end

        // Reset asserted in the middle of RELEASE
        bus.locked = 1'b0;
        repeat (3) tick();
        bus.locked = 1'b1;
        repeat (20) tick();
        check("pre_reset_mem", int'(bus.rst_mem), 0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outs", outs(), 4'b1110);
        check("async_reset_count", int'(bus.lock_loss_count), 0);
        tick();
        reset = 1'b0;
        mem_fall = 0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (mem_fall == 0 && !bus.rst_mem) mem_fall = k;
        end
        check_range("restart_mem_fall", mem_fall, 17, 19);

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
        begin
            int first_rise, second_rise, width1, hold_err;
            logic prev;
            first_rise = 0; second_rise = 0; width1 = 0; hold_err = 0; prev = 1'b0;
            bus.locked = 1'b0;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            for (int k = 1; k <= 160; k++) begin
                tick();
                if (bus.pll_rst && !prev) begin
                    if (first_rise == 0) first_rise = k;
                    else if (second_rise == 0) second_rise = k;
                end
                if (bus.pll_rst && second_rise == 0) width1++;
                if (bus.pll_rst && !(bus.rst_mem && bus.rst_func && bus.rst_cpu)) hold_err++;
                prev = bus.pll_rst;
            end
            check_range("wdt_first_rise", first_rise, 63, 65);
            check("wdt_width", width1, 8);
            check("wdt_period", second_rise - first_rise, 72);
            check("wdt_resets_held", hold_err, 0);
            check("wdt_no_loss", int'(bus.lock_loss_count), 0);
        end
`else
        check("pll_rst_never", int'(pll_rst_seen), 0);
`endif

        check("stage_order", order_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Consumes the PLL `locked` indication and drives the staged reset releases for the clock domains the PLL feeds, in a single clock domain. Resets are released in order: memory controller, CPU functional units, CPU core. Loss of lock re-asserts all resets and is counted. An optional watchdog pulses the PLL's own reset when lock never arrives.

## Interface
- `SYNC_STAGES`, 2: flops in the `locked` synchroniser (minimum 2).
- `STABLE_CYCLES`, 1024: consecutive synchronised-lock cycles required before release.
- `STAGE_GAP`, 16: cycles between successive reset releases.
- `TIMEOUT_CYCLES`, 65536: watchdog limit in WAIT_LOCK (watchdog build only).
- `PLLRST_CYCLES`, 8: width of the `pll_rst` pulse (watchdog build only).
- `CNT_W`, 8: width of the lock-loss counter.
- `clock  in  1`: the sequencer's only clock.
- `reset  in  1`: asynchronous, active-high.
- `locked  in  1`: raw PLL lock, asynchronous to `clock`.
- `count_clr  in  1`: single-cycle clear of `lock_loss_count`.
- `rst_mem  out  1`: active-high reset for the memory controller domain.
- `rst_func  out  1`: active-high reset for the CPU functional units.
- `rst_cpu  out  1`: active-high reset for the CPU core.
- `ready  out  1`: high when all resets are released.
- `pll_rst  out  1`: reset request to the PLL. Constant 0 unless the watchdog is compiled in.
- `lock_loss_count  out  CNT_W`: saturating count of lock losses after release began.

## Operation
- On `reset`, all of these take effect immediately: `rst_mem`, `rst_func` and `rst_cpu` go to 1; `ready`, `pll_rst` and `lock_loss_count` go to 0; state is WAIT_LOCK; all internal counters are 0.
- `locked` passes through SYNC_STAGES flops, which are cleared by `reset`, to give `lock_s`. Only `lock_s` is used by the rest of the block.
- WAIT_LOCK:
  - All resets held at 1.
  - `lock_s`=1 → STABLE, with the stable counter at 0.
- STABLE:
  - The counter increments on each cycle that `lock_s`=1.
  - `lock_s`=0 → WAIT_LOCK. This is not counted as a loss.
  - Counter reaches STABLE_CYCLES-1 → RELEASE.
- RELEASE:
  - `rst_mem` falls on the edge that enters RELEASE.
  - `rst_func` falls STAGE_GAP edges later.
  - `rst_cpu` falls STAGE_GAP edges after `rst_func`. `ready` rises on that same edge, and the state becomes RUN.
- RUN: outputs hold.
- Lock loss (`lock_s`=0 in RELEASE or RUN):
  - On the next edge, all three resets return to 1 and `ready` goes to 0.
  - `lock_loss_count` increments, saturating at all-ones.
  - State → WAIT_LOCK.
- Reset outputs are registered and glitch-free. A reset output never deasserts while a reset for an earlier stage is still asserted.
- `count_clr` and an increment on the same edge: the result is 1. `count_clr` alone: the result is 0.

## Timing
- Latency from a `locked` rise to the `rst_mem` fall is SYNC_STAGES+STABLE_CYCLES edges, +1 for synchroniser uncertainty.
- `rst_mem` fall → `rst_func` fall: exactly STAGE_GAP cycles.
- `rst_func` fall → `rst_cpu` fall and `ready` rise: exactly STAGE_GAP cycles.
- Latency from a `locked` fall to the resets asserting is SYNC_STAGES+1 edges.
- A `locked` glitch shorter than one cycle may be missed; this is acceptable. Any glitch that reaches `lock_s` forces a full restart of the stable count.
- Asserting `reset` mid-sequence forces the reset-state values asynchronously. After `reset` falls, the sequence restarts from WAIT_LOCK.

## Configuration
- Macro: `PLL_RESET_SEQ_WATCHDOG_EN`.
- Defined:
  - A timeout counter runs only in WAIT_LOCK and clears on leaving that state.
  - When it reaches TIMEOUT_CYCLES-1, the state goes to PLLRST. In PLLRST, `pll_rst`=1 for exactly PLLRST_CYCLES cycles, all resets are held at 1, and `lock_s` is ignored.
  - PLLRST then returns to WAIT_LOCK with the timeout counter at 0.
  - PLLRST does not count as a lock loss.
- Undefined: no PLLRST state and no timeout counter; `pll_rst` is tied to 0. WAIT_LOCK waits indefinitely.

## Structure
- Package `pll_reset_pkg`:
  - State enum: WAIT_LOCK, STABLE, RELEASE, RUN, PLLRST. PLLRST is always declared; it is reachable only in the watchdog build.
  - Counter-width helper constants, derived with `$clog2` of the parameters.
- One sub-module, `lock_synchroniser`: a parameterised SYNC_STAGES flop chain with asynchronous clear.
- Top level contains the FSM, the shared stable/stage counter, the watchdog counter and the loss counter. Target 150–300 lines.

## Test plan
Bench parameters: STABLE_CYCLES=16, STAGE_GAP=4, SYNC_STAGES=2, TIMEOUT_CYCLES=64, PLLRST_CYCLES=8, CNT_W=2.
- **Clean lock:** `locked` rises at cycle 0 → `rst_mem` falls at 18±1, `rst_func` at 22±1, `rst_cpu` and `ready` at 26±1. Count stays 0.
- **Unstable lock:** `locked` high 10 cycles, low 1, then high → no release before 10+1+18 cycles. Count stays 0.
- **Loss in RUN:** drop `locked` → all resets reassert within 3 cycles and count becomes 1. Repeat 4 losses → count saturates at 3.
- **Loss in RELEASE:** drop `locked` 2 cycles after `rst_mem` falls → all resets reassert and count increments. `rst_cpu` never falls.
- **Clear priority:** `count_clr` on the same edge as a loss with count 3 → count becomes 1. `count_clr` alone → 0.
- **Watchdog build:** `locked` held low → `pll_rst` high for 8 cycles starting at cycle 64±1, repeating every 72 cycles. Non-watchdog build → `pll_rst` is always 0. Asserting `reset` mid-RELEASE → all resets 1 immediately.
